// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the three-port SDRAM arbiter.
package sdram_arb_pkg;

    typedef enum logic [1:0] {
        REQ_CART = 2'd0,
        REQ_LDR  = 2'd1,
        REQ_DBG  = 2'd2
    } req_id_e;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RELEASE,
        RESPOND
    } state_e;

    localparam logic [15:0] TIMEOUT_DATA = 16'hDEAD;

endpackage

// File: rtl/sdram_arb_select.sv
// Grant selection: cart priority with a bypass limit, round-robin between loader and debug.
module sdram_arb_select
    import sdram_arb_pkg::*;
#(
    parameter int unsigned MAX_BYPASS = 4
) (
    input  logic    clk_i,
    input  logic    rst_ni,
    input  logic    grant_en_i,
    input  logic    cart_req_i,
    input  logic    ldr_req_i,
    input  logic    dbg_req_i,
    output logic    gnt_valid_o,
    output req_id_e gnt_id_o
);

    localparam int unsigned BypW = (MAX_BYPASS > 0) ? $clog2(MAX_BYPASS + 1) : 1;

    logic [BypW-1:0] bypass_q, bypass_d;
    req_id_e         rr_q, rr_d;
    logic            low_pend, force_low;

    always_comb begin
        low_pend    = ldr_req_i | dbg_req_i;
        force_low   = low_pend && (bypass_q == BypW'(MAX_BYPASS));
        gnt_valid_o = cart_req_i | low_pend;
        gnt_id_o    = REQ_CART;
        // rr_q names the low-tier requester that wins a tie
        if (!(cart_req_i && !force_low) && low_pend) begin
            if (rr_q == REQ_LDR) begin
                gnt_id_o = ldr_req_i ? REQ_LDR : REQ_DBG;
            end else begin
                gnt_id_o = dbg_req_i ? REQ_DBG : REQ_LDR;
            end
        end
    end

    always_comb begin
        bypass_d = bypass_q;
        rr_d     = rr_q;
        if (grant_en_i && gnt_valid_o) begin
            if (gnt_id_o == REQ_CART) begin
                if (low_pend && (bypass_q != BypW'(MAX_BYPASS))) begin
                    bypass_d = bypass_q + BypW'(1);
                end
            end else begin
                bypass_d = '0;
                rr_d     = (gnt_id_o == REQ_LDR) ? REQ_DBG : REQ_LDR;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bypass_q <= '0;
            rr_q     <= REQ_LDR;
        end else begin
            bypass_q <= bypass_d;
            rr_q     <= rr_d;
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares one SDRAM controller between cart read, loader write and debug read ports,
// with 4-phase handshakes on both sides and a controller-ack timeout.
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned MAX_BYPASS = 4,
    parameter int unsigned TIMEOUT    = 1023
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              cart_req_i,
    input  logic [ADDR_W-1:0] cart_addr_i,
    output logic              cart_ack_o,
    output logic [DATA_W-1:0] cart_data_o,
    input  logic              ldr_req_i,
    input  logic [ADDR_W-1:0] ldr_addr_i,
    input  logic [DATA_W-1:0] ldr_data_i,
    output logic              ldr_ack_o,
    input  logic              dbg_req_i,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    output logic              dbg_ack_o,
    output logic [DATA_W-1:0] dbg_data_o,
    output logic              mem_wr_o,
    output logic [ADDR_W-1:0] mem_waddr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_wack_i,
    output logic              mem_rd_o,
    output logic [ADDR_W-1:0] mem_raddr_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_rack_i,
    output logic              busy_o,
    output logic              err_o
);

    localparam int unsigned TmoW = $clog2(TIMEOUT + 1);

    state_e            state_q, state_d;
    req_id_e           id_q, id_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [TmoW-1:0]   tmo_q, tmo_d;
    logic              err_q, err_d;

    logic    gnt_valid;
    req_id_e gnt_id;
    logic    is_wr, mem_ack, tmo_hit, winner_req;

    assign is_wr      = (id_q == REQ_LDR);
    assign mem_ack    = is_wr ? mem_wack_i : mem_rack_i;
    assign tmo_hit    = (tmo_q == TmoW'(TIMEOUT - 1));
    assign winner_req = (id_q == REQ_LDR) ? ldr_req_i :
                        (id_q == REQ_DBG) ? dbg_req_i : cart_req_i;

    assign cart_ack_o  = (state_q == RESPOND) && (id_q == REQ_CART);
    assign ldr_ack_o   = (state_q == RESPOND) && (id_q == REQ_LDR);
    assign dbg_ack_o   = (state_q == RESPOND) && (id_q == REQ_DBG);
    assign cart_data_o = rdata_q;
    assign dbg_data_o  = rdata_q;
    assign mem_wr_o    = (state_q == ISSUE) && is_wr;
    assign mem_rd_o    = (state_q == ISSUE) && !is_wr;
    assign mem_waddr_o = addr_q;
    assign mem_raddr_o = addr_q;
    assign mem_wdata_o = wdata_q;
    assign busy_o      = (state_q != IDLE);
    assign err_o       = err_q;

    sdram_arb_select #(
        .MAX_BYPASS(MAX_BYPASS)
    ) u_select (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .grant_en_i (state_q == IDLE),
        .cart_req_i (cart_req_i & ~cart_ack_o),
        .ldr_req_i  (ldr_req_i & ~ldr_ack_o),
        .dbg_req_i  (dbg_req_i & ~dbg_ack_o),
        .gnt_valid_o(gnt_valid),
        .gnt_id_o   (gnt_id)
    );

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        tmo_d   = '0;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    state_d = ISSUE;
                    id_d    = gnt_id;
                    wdata_d = ldr_data_i;
                    case (gnt_id)
                        REQ_LDR: addr_d = ldr_addr_i;
                        REQ_DBG: addr_d = dbg_addr_i;
                        default: addr_d = cart_addr_i;
                    endcase
                end
            end
            ISSUE, RELEASE: begin
                tmo_d = tmo_q + TmoW'(1);
                // Timeout wins over a same-cycle ack so the abort is unambiguous
                if (tmo_hit) begin
                    state_d = RESPOND;
                    err_d   = 1'b1;
                    rdata_d = DATA_W'(TIMEOUT_DATA);
                    tmo_d   = '0;
                end else if ((state_q == ISSUE) && mem_ack) begin
                    state_d = RELEASE;
                    if (!is_wr) begin
                        rdata_d = mem_rdata_i;
                    end
                end else if ((state_q == RELEASE) && !mem_ack) begin
                    state_d = RESPOND;
                    tmo_d   = '0;
                end
            end
            RESPOND: begin
                if (!winner_req) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            id_q    <= REQ_CART;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Self-checking bench: requester agents, a controller model and a grant-order reference model.
module tb_sdram_port_arbiter;

    localparam int unsigned AW   = 32;
    localparam int unsigned DW   = 16;
    localparam int          MAXB = 4;
    localparam int          TMO  = 1023;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cart_req = 1'b0, ldr_req = 1'b0, dbg_req = 1'b0;
    logic [AW-1:0] cart_addr = '0, ldr_addr = '0, dbg_addr = '0;
    logic [DW-1:0] ldr_data = '0;
    logic          cart_ack, ldr_ack, dbg_ack;
    logic [DW-1:0] cart_data, dbg_data;
    logic          mem_wr, mem_rd, busy, err;
    logic [AW-1:0] mem_waddr, mem_raddr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_wack = 1'b0, mem_rack = 1'b0;

    always #5 clk = ~clk;

    sdram_port_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .MAX_BYPASS(MAXB), .TIMEOUT(TMO)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .cart_req_i(cart_req), .cart_addr_i(cart_addr), .cart_ack_o(cart_ack),
        .cart_data_o(cart_data),
        .ldr_req_i(ldr_req), .ldr_addr_i(ldr_addr), .ldr_data_i(ldr_data), .ldr_ack_o(ldr_ack),
        .dbg_req_i(dbg_req), .dbg_addr_i(dbg_addr), .dbg_ack_o(dbg_ack), .dbg_data_o(dbg_data),
        .mem_wr_o(mem_wr), .mem_waddr_o(mem_waddr), .mem_wdata_o(mem_wdata), .mem_wack_i(mem_wack),
        .mem_rd_o(mem_rd), .mem_raddr_o(mem_raddr), .mem_rdata_i(mem_rdata), .mem_rack_i(mem_rack),
        .busy_o(busy), .err_o(err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Small address table so reads and writes collide often
    logic [31:0] tbl [8] = '{32'h0000_1000, 32'h0200_0004, 32'h0000_0000, 32'h0000_0002,
                             32'h00FF_FFFE, 32'h01FF_FFFE, 32'h1234_5678, 32'hFFFF_FFFE};
    logic [15:0] ctl_mem [8];
    logic [15:0] ref_mem [8];

    function automatic int slot(input logic [31:0] a);
        for (int i = 0; i < 8; i++) if (tbl[i] == a) return i;
        return 0;
    endfunction

    // Controller model: 4-phase ack after a programmable delay
    bit ctl_mute = 1'b0;
    bit ctl_rand = 1'b0;
    int ctl_dly  = 2;
    int rcnt = 0, wcnt = 0, rrnd = 1, wrnd = 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_rack <= 1'b0;
            mem_wack <= 1'b0;
            rcnt     <= 0;
            wcnt     <= 0;
        end else begin
            if (mem_rd && !mem_rack && !ctl_mute) begin
                if (rcnt >= (ctl_rand ? rrnd : ctl_dly)) begin
                    mem_rack  <= 1'b1;
                    mem_rdata <= ctl_mem[slot(mem_raddr)];
                    rcnt      <= 0;
                    rrnd      <= int'($urandom_range(0, 5));
                end else begin
                    rcnt <= rcnt + 1;
                end
            end else if (!mem_rd && mem_rack) begin
                mem_rack <= 1'b0;
            end
            if (mem_wr && !mem_wack && !ctl_mute) begin
                if (wcnt >= (ctl_rand ? wrnd : ctl_dly)) begin
                    mem_wack                <= 1'b1;
                    ctl_mem[slot(mem_waddr)] <= mem_wdata;
                    wcnt                    <= 0;
                    wrnd                    <= int'($urandom_range(0, 5));
                end else begin
                    wcnt <= wcnt + 1;
                end
            end else if (!mem_wr && mem_wack) begin
                mem_wack <= 1'b0;
            end
        end
    end

    // Reference model of the grant rules, evaluated at every grant the DUT makes
    int m_byp = 0;
    int m_rr  = 1;
    int exp_q [$];
    int glog [$];
    int rd_cyc = 0;
    int err_cnt = 0;

    initial begin
        logic [2:0] pend, ack_now, ack_prev;
        bit was_idle, low;
        int w;
        ack_prev = '0;
        forever begin
            @(posedge clk);
            pend     = {dbg_req, ldr_req, cart_req};
            was_idle = (busy === 1'b0);
            #1;
            if (!rst_n) begin
                m_byp = 0;
                m_rr  = 1;
                exp_q.delete();
                ack_prev = '0;
                continue;
            end
            if (mem_rd === 1'b1) rd_cyc++;
            if (err === 1'b1) err_cnt++;
            if (was_idle && busy === 1'b1) begin
                low = pend[1] | pend[2];
                w   = 9;
                if (pend[0] && !(m_byp == MAXB && low)) begin
                    w = 0;
                    if (low && m_byp < MAXB) m_byp++;
                end else if (low) begin
                    if (m_rr == 1) w = pend[1] ? 1 : 2;
                    else w = pend[2] ? 2 : 1;
                    m_rr  = (w == 1) ? 2 : 1;
                    m_byp = 0;
                end
                exp_q.push_back(w);
            end
            ack_now = {dbg_ack, ldr_ack, cart_ack};
            for (int k = 0; k < 3; k++) begin
                if (ack_now[k] && !ack_prev[k]) begin
                    glog.push_back(k);
                    if (exp_q.size() == 0) chk("grant_unpredicted", k, 9);
                    else chk("grant_order", k, exp_q.pop_front());
                end
            end
            ack_prev = ack_now;
        end
    end

    // Requester agents
    typedef struct {
        logic [31:0] addr;
        logic [15:0] data;
        int          hold;
        int          gap;
        bit          tmo;
    } item_t;

    item_t q_c [$];
    item_t q_l [$];
    item_t q_d [$];
    int    done_n [3] = '{0, 0, 0};
    int    tot_n  [3] = '{0, 0, 0};

    function automatic int q_size(input int id);
        case (id)
            0:       return q_c.size();
            1:       return q_l.size();
            default: return q_d.size();
        endcase
    endfunction

    function automatic item_t q_pop(input int id);
        case (id)
            0:       return q_c.pop_front();
            1:       return q_l.pop_front();
            default: return q_d.pop_front();
        endcase
    endfunction

    function automatic logic get_ack(input int id);
        case (id)
            0:       return cart_ack;
            1:       return ldr_ack;
            default: return dbg_ack;
        endcase
    endfunction

    function automatic logic [15:0] get_data(input int id);
        return (id == 0) ? cart_data : dbg_data;
    endfunction

    task automatic set_req(input int id, input logic v, input logic [31:0] a, input logic [15:0] d);
        case (id)
            0: begin cart_req = v; cart_addr = a; end
            1: begin ldr_req = v; ldr_addr = a; ldr_data = d; end
            default: begin dbg_req = v; dbg_addr = a; end
        endcase
    endtask

    task automatic agent(input int id);
        item_t it;
        int    n;
        bit    abort;
        forever begin
            @(negedge clk);
            while (q_size(id) != 0) begin
                it = q_pop(id);
                repeat (it.gap) @(negedge clk);
                set_req(id, 1'b1, it.addr, it.data);
                n     = 0;
                abort = 1'b0;
                do begin
                    @(negedge clk);
                    n++;
                    if (!rst_n) abort = 1'b1;
                end while (get_ack(id) !== 1'b1 && !abort && n < 2000);
                if (abort) begin
                    set_req(id, 1'b0, it.addr, it.data);
                end else if (n >= 2000) begin
                    chk("ack_wait_expired", id, 99);
                    set_req(id, 1'b0, it.addr, it.data);
                end else begin
                    if (id == 1) ref_mem[slot(it.addr)] = it.data;
                    else chk("read_data", get_data(id), it.tmo ? 32'hDEAD : ref_mem[slot(it.addr)]);
                    repeat (it.hold) @(negedge clk);
                    if (it.hold != 0) chk("ack_held", get_ack(id), 1);
                    set_req(id, 1'b0, it.addr, it.data);
                    @(negedge clk);
                    chk("ack_drop", get_ack(id), 0);
                end
                done_n[id]++;
            end
        end
    endtask

    initial agent(0);
    initial agent(1);
    initial agent(2);

    task automatic push(input int id, input logic [31:0] a, input logic [15:0] d,
                        input int hold, input int gap, input bit tmo);
        item_t it;
        it.addr = a; it.data = d; it.hold = hold; it.gap = gap; it.tmo = tmo;
        case (id)
            0:       q_c.push_back(it);
            1:       q_l.push_back(it);
            default: q_d.push_back(it);
        endcase
        tot_n[id]++;
    endtask

    task automatic sync();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_all(input int budget, input string tag);
        int n = 0;
        while ((done_n[0] < tot_n[0] || done_n[1] < tot_n[1] || done_n[2] < tot_n[2])
               && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, (done_n[0] >= tot_n[0]) && (done_n[1] >= tot_n[1]) && (done_n[2] >= tot_n[2]), 1);
    endtask

    task automatic check_log(input string tag, input int exp[$]);
        chk({tag, "_len"}, glog.size(), exp.size());
        for (int i = 0; i < exp.size() && i < glog.size(); i++) chk(tag, glog[i], exp[i]);
    endtask

    initial begin
        int n, rd0, e0;
        int exp4[$], exp5[$];
        for (int i = 0; i < 8; i++) begin
            ctl_mem[i] = tbl[i][15:0] ^ 16'hA5C3;
            ref_mem[i] = tbl[i][15:0] ^ 16'hA5C3;
        end
        ctl_mem[0] = 16'hBEEF;
        ref_mem[0] = 16'hBEEF;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_mem_rd", mem_rd, 0);
        chk("rst_mem_wr", mem_wr, 0);
        chk("rst_acks", {cart_ack, ldr_ack, dbg_ack}, 0);
        chk("rst_err", err, 0);
        chk("rst_cart_data", cart_data, 0);
        chk("rst_raddr", mem_raddr, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Cart read, controller answers after 6 cycles
        ctl_dly = 6;
        sync();
        push(0, 32'h0000_1000, 16'h0, 1, 0, 1'b0);
        n = 0;
        while (mem_rd !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        chk("cart_mem_rd", mem_rd, 1);
        chk("cart_raddr", mem_raddr, 32'h0000_1000);
        wait_all(200, "cart_done");

        // Loader write
        ctl_dly = 2;
        rd0 = rd_cyc;
        sync();
        push(1, 32'h0200_0004, 16'h1234, 0, 0, 1'b0);
        n = 0;
        while (mem_wr !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        chk("ldr_mem_wr", mem_wr, 1);
        chk("ldr_waddr", mem_waddr, 32'h0200_0004);
        chk("ldr_wdata", mem_wdata, 16'h1234);
        n = 0;
        while (ldr_ack !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        chk("ldr_ack_seen", ldr_ack, 1);
        chk("ldr_ack_after_wack", mem_wack, 0);
        wait_all(200, "ldr_done");
        chk("ldr_no_rd", rd_cyc, rd0);
        chk("ldr_stored", ctl_mem[1], 16'h1234);

        // Cart streaming while loader waits
        ctl_dly = 1;
        glog.delete();
        sync();
        for (int i = 0; i < 6; i++) push(0, tbl[$urandom_range(0, 7)], 16'h0, 0, 0, 1'b0);
        push(1, tbl[$urandom_range(2, 7)], 16'($urandom), 0, 0, 1'b0);
        wait_all(500, "bypass_done");
        exp4 = '{0, 0, 0, 0, 1, 0, 0};
        check_log("bypass_order", exp4);

        // Fresh RR pointer, loader and debug contending
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        glog.delete();
        sync();
        for (int i = 0; i < 2; i++) begin
            push(1, tbl[$urandom_range(2, 7)], 16'($urandom), 0, 0, 1'b0);
            push(2, tbl[$urandom_range(0, 7)], 16'h0, 0, 0, 1'b0);
        end
        wait_all(500, "rr_done");
        exp5 = '{1, 2, 1, 2};
        check_log("rr_order", exp5);

        // Controller never acks a debug read
        ctl_mute = 1'b1;
        e0 = err_cnt;
        sync();
        push(2, tbl[3], 16'h0, 1, 0, 1'b1);
        n = 0;
        while (mem_rd !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        chk("tmo_rd_up", mem_rd, 1);
        n = 0;
        while (err !== 1'b1 && n < 1200) begin @(negedge clk); n++; end
        chk("tmo_window", (n >= TMO - 1) && (n <= TMO + 3), 1);
        chk("tmo_rd_dropped", mem_rd, 0);
        wait_all(200, "tmo_done");
        chk("tmo_err_once", err_cnt - e0, 1);
        chk("tmo_idle", busy, 0);
        ctl_mute = 1'b0;

        // Reset while a cart read sits in ISSUE
        ctl_mute = 1'b1;
        sync();
        push(0, tbl[4], 16'h0, 0, 0, 1'b0);
        n = 0;
        while (mem_rd !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        chk("rstmid_rd_up", mem_rd, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstmid_rd", mem_rd, 0);
        chk("rstmid_wr", mem_wr, 0);
        chk("rstmid_acks", {cart_ack, ldr_ack, dbg_ack}, 0);
        chk("rstmid_busy", busy, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        ctl_mute = 1'b0;
        wait_all(100, "rstmid_abandon");
        sync();
        push(0, tbl[5], 16'h0, 0, 0, 1'b0);
        wait_all(200, "rstmid_next");

        // Randomized traffic
        ctl_rand = 1'b1;
        e0 = err_cnt;
        sync();
        for (int i = 0; i < 25; i++)
            push(0, tbl[$urandom_range(0, 7)], 16'h0, $urandom_range(0, 3), $urandom_range(0, 4), 1'b0);
        for (int i = 0; i < 12; i++) begin
            push(1, tbl[$urandom_range(0, 7)], 16'($urandom), $urandom_range(0, 3),
                 $urandom_range(0, 4), 1'b0);
            push(2, tbl[$urandom_range(0, 7)], 16'h0, $urandom_range(0, 3), $urandom_range(0, 4), 1'b0);
        end
        wait_all(6000, "random_done");
        chk("random_no_err", err_cnt, e0);
        repeat (3) @(negedge clk);
        chk("grants_all_acked", exp_q.size(), 0);
        chk("final_idle", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
- Shares the single 32 MB SDRAM controller between three requesters:
  - cart read port: N64 PI bus, latency-critical.
  - loader write port: SD/USB ROM loader.
  - debug read port: host readback.
- Each requester uses a 4-phase req/ack handshake. The arbiter drives the controller's writeport/readport 4-phase handshake.
- Provides fixed priority, starvation guard, timeout and busy/error status.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 16, data width of all ports.
- MAX_BYPASS, 4, consecutive cart grants allowed while loader/debug is pending before a low-tier grant is forced.
- TIMEOUT, 1023, cycles to wait for controller ack before abort.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- cart_req  in  1  cart read request (level).
- cart_addr  in  ADDR_W  cart read address.
- cart_ack  out  1  cart read done.
- cart_data  out  DATA_W  cart read data.
- ldr_req  in  1  loader write request.
- ldr_addr  in  ADDR_W  loader write address.
- ldr_data  in  DATA_W  loader write data.
- ldr_ack  out  1  loader write done.
- dbg_req  in  1  debug read request.
- dbg_addr  in  ADDR_W  debug read address.
- dbg_ack  out  1  debug read done.
- dbg_data  out  DATA_W  debug read data.
- mem_wr  out  1  controller writeport_wr.
- mem_waddr  out  ADDR_W  controller writeport_addr.
- mem_wdata  out  DATA_W  controller writeport_data.
- mem_wack  in  1  controller writeport_ack.
- mem_rd  out  1  controller readport_rd.
- mem_raddr  out  ADDR_W  controller readport_addr.
- mem_rdata  in  DATA_W  controller readport_data.
- mem_rack  in  1  controller readport_ack.
- busy  out  1  high in any state except IDLE.
- err  out  1  one-cycle pulse on timeout.

Behaviour:
- Reset (rst low, async): state IDLE; all outputs 0; bypass counter 0; RR pointer = loader; timeout counter 0.
- Reset mid-transaction abandons it. Requesters must re-request after reset.
- Requester handshake:
  - Requester raises req with addr/data stable.
  - Arbiter latches addr/data at grant, then raises ack (read data valid and held while ack high).
  - Requester drops req; arbiter drops ack the next cycle.
  - A requester whose ack is high is not eligible for a grant.
- State machine: IDLE -> ISSUE -> RELEASE -> RESPOND -> IDLE.
- IDLE, grant selection:
  - Cart wins if cart_req is set, unless bypass == MAX_BYPASS and a low-tier request is pending.
  - Low tier (ldr, dbg) is round-robin; the pointer advances past the winner.
  - Grant latches the winner id, addr and data into registers, and moves to ISSUE the next cycle.
  - Bypass counter:
    - Increments on each cart grant while a low-tier request is pending.
    - Clears on a low-tier grant.
    - Saturates at MAX_BYPASS.
- ISSUE: mem_wr (loader) or mem_rd (reads) is high, with registered addr/data. Stays until the matching mem ack is high; read data is captured on that cycle. Moves to RELEASE.
- RELEASE: mem_wr/mem_rd low; wait for the mem ack to go low. Moves to RESPOND.
- RESPOND: winner's ack high (data held); wait for winner's req low, then drop ack. Moves to IDLE.
- Minimum cart latency, cart_req high to cart_ack high: 4 cycles plus controller ack delay.
- Timeout:
  - The counter runs in ISSUE and RELEASE.
  - Reaching TIMEOUT: err pulses once, mem_wr/mem_rd drop, and the state goes to RESPOND. Read data is 16'hDEAD; the write is lost.
- Simultaneous cart_req+ldr_req+dbg_req with bypass<MAX: cart first, then per RR.
- A req that drops before grant is simply not granted; no error.
- A req that drops while in ISSUE is ignored; the transaction completes and the ack pulses for one cycle.
- Addresses pass through unmodified. Address alignment is the controller's responsibility.

Decomposition:
- Package sdram_arb_pkg:
  - requester id enum (REQ_CART=0, REQ_LDR=1, REQ_DBG=2).
  - state enum (IDLE, ISSUE, RELEASE, RESPOND).
  - constant TIMEOUT_DATA = 16'hDEAD.
- One sub-module, sdram_arb_select: combinational priority/RR/bypass selection plus registered RR pointer and bypass counter. The top level holds the FSM and datapath.

Test Plan:
- Cart read of 0x0000_1000, model returns 0xBEEF after 6 cycles -> mem_rd high with mem_raddr=0x1000; cart_data=0xBEEF with cart_ack; ack drops 1 cycle after cart_req drops.
- Loader write 0x0200_0004/0x1234 -> mem_wr, mem_waddr=0x0200_0004, mem_wdata=0x1234; ldr_ack after mem_wack falls; no mem_rd activity.
- Cart requesting continuously and ldr_req held, MAX_BYPASS=4 -> exactly 4 cart grants, then 1 loader grant, then cart resumes.
- ldr_req and dbg_req together, repeated 4 times, no cart -> grants alternate LDR, DBG, LDR, DBG.
- Controller never acks a dbg read -> after 1023 cycles err pulses once, dbg_data=0xDEAD, dbg_ack high, FSM returns to IDLE.
- rst low during ISSUE -> mem_rd/mem_wr and all acks 0 immediately (async); busy=0; next request is served normally.
